// File: rtl/seq_logic_alu_pkg.sv
// Shared definitions for the sequential logic ALU: function-select codes
// and the control FSM state encoding.
package seq_logic_pkg;

    localparam logic [2:0] OP_NOT   = 3'b000;
    localparam logic [2:0] OP_NOR   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_XNOR  = 3'b101;
    localparam logic [2:0] OP_NAND  = 3'b110;
    localparam logic [2:0] OP_NAND2 = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

endpackage

// File: rtl/seq_logic_alu_logic_slice.sv
// Combinational DIGIT-bit slice of the two-operand logic function table.
module alu_logic_slice
    import seq_logic_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic [2:0]       sel,
    output logic [DIGIT-1:0] out
);

    // Per-bit function selection; OP_NAND2 is a legacy alias of OP_NAND.
    always_comb begin
        out = {DIGIT{1'b0}};
        case (sel)
            OP_NOT:   out = ~a;
            OP_NOR:   out = ~(a | b);
            OP_AND:   out = a & b;
            OP_OR:    out = a | b;
            OP_XOR:   out = a ^ b;
            OP_XNOR:  out = ~(a ^ b);
            OP_NAND:  out = ~(a & b);
            OP_NAND2: out = ~(a & b);
            default:  out = ~(a & b);
        endcase
    end

endmodule

// File: rtl/seq_logic_alu.sv
// Multi-cycle logic unit: captures operands, runs them DIGIT bits per clock
// through a shared slice, then holds the result until the sink accepts it.
module seq_logic_alu
    import seq_logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             parity
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("seq_logic_alu: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    // Even-parity helper: XOR reduction of a result word.
    function automatic logic parity_f(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [DIGIT-1:0] slice_s;
    logic [WIDTH-1:0] res_shift_s;

    alu_logic_slice #(.DIGIT(DIGIT)) u_slice (
        .a   (sa_q[DIGIT-1:0]),
        .b   (sb_q[DIGIT-1:0]),
        .sel (op_q),
        .out (slice_s)
    );

    // Result shifts right; the new slice enters at the top so the word is
    // complete, LSB-aligned, after STEPS cycles.
    assign res_shift_s = (res_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));

    // Next-state and datapath control for IDLE/RUN/HOLD.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        op_d     = op_q;
        res_d    = res_q;
        out_d    = out_q;
        acc_d    = acc_q;
        zero_d   = zero_q;
        parity_d = parity_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sa_d    = a;
                    sb_d    = use_acc ? acc_q : b;
                    op_d    = sel;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sa_d  = sa_q >> DIGIT;
                sb_d  = sb_q >> DIGIT;
                res_d = res_shift_s;
                cnt_d = cnt_q + CW'(1'b1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    out_d    = res_shift_s;
                    acc_d    = res_shift_s;
                    zero_d   = (res_shift_s == {WIDTH{1'b0}});
                    parity_d = parity_f(res_shift_s);
                    state_d  = ST_HOLD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        out_valid_d = (state_d == ST_HOLD);
        in_ready_d  = (state_d == ST_IDLE);
    end

    // State and datapath registers; reset aborts any operation and clears acc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            sa_q        <= {WIDTH{1'b0}};
            sb_q        <= {WIDTH{1'b0}};
            op_q        <= 3'b000;
            res_q       <= {WIDTH{1'b0}};
            out_q       <= {WIDTH{1'b0}};
            acc_q       <= {WIDTH{1'b0}};
            zero_q      <= 1'b0;
            parity_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            op_q        <= op_d;
            res_q       <= res_d;
            out_q       <= out_d;
            acc_q       <= acc_d;
            zero_q      <= zero_d;
            parity_q    <= parity_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign zero      = zero_q;
    assign parity    = parity_q;

endmodule
